mem_fill_arbiter: RTL and testbench

//  Shares the single pipelined main memory between I-cache and D-cache miss fills and D-cache write-through stores.

---
 rtl/mem_fill_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Arbitrates one pipelined main memory between I/D block fills and D write-through stores.
// Define ARB_RR_EN to alternate grants on simultaneous I/D misses; default is fixed D-over-I priority.
module mem_fill_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         icache_miss,
  input  logic [ADDR_W-1:0]            icache_miss_addr,
  input  logic                         dcache_miss,
  input  logic [ADDR_W-1:0]            dcache_miss_addr,
  input  logic                         dmem_wr_req,
  input  logic [ADDR_W-1:0]            dmem_wr_addr,
  input  logic [DATA_W-1:0]            dmem_wr_data,
  output logic                         dmem_wr_ack,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_data_valid,
  output logic [DATA_W-1:0]            fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic                         fill_we_i,
  output logic                         fill_we_d,
  output logic                         fill_done_i,
  output logic                         fill_done_d,
  output logic                         i_stall,
  output logic                         d_stall
);

  localparam int WORD_W = $clog2(BLK_WORDS);
  localparam int CNT_W  = WORD_W + 1;
  localparam int OFF_W  = WORD_W + 1;  // byte offset bits within a block of 16-bit words
  localparam int BASE_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLK_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_e;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic               grant_i, grant_d;
`ifdef ARB_RR_EN
  owner_e             last_grant_q, last_grant_d;
`endif

  // Block alignment discards the offset bits of the miss addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_miss_addr[OFF_W-1:0], dcache_miss_addr[OFF_W-1:0]};

  // NOTE: reset is synchronous, so it lives inside the clocked block rather than its sensitivity list.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_D;
      base_q       <= '0;
      req_cnt_q    <= '0;
      rcv_cnt_q    <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= OWN_I;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      req_cnt_q    <= req_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    // A pending store always wins the IDLE cycle; misses retry next cycle.
    if (state_q == S_IDLE && !dmem_wr_req) begin
`ifdef ARB_RR_EN
      if (icache_miss && dcache_miss) begin
        grant_d = (last_grant_q == OWN_I);
        grant_i = ~grant_d;
      end else begin
        grant_d = dcache_miss;
        grant_i = icache_miss;
      end
`else
      grant_d = dcache_miss;
      grant_i = icache_miss & ~dcache_miss;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (grant_i || grant_d) begin
          state_d   = S_FILL;
          owner_d   = grant_i ? OWN_I : OWN_D;
          base_d    = grant_i ? icache_miss_addr[ADDR_W-1:OFF_W] : dcache_miss_addr[ADDR_W-1:OFF_W];
          req_cnt_d = '0;
          rcv_cnt_d = '0;
`ifdef ARB_RR_EN
          last_grant_d = grant_i ? OWN_I : OWN_D;
`endif
        end
      end
      S_FILL: begin
        if (req_cnt_q < BLK_CNT) req_cnt_d = req_cnt_q + CNT_W'(1);
        if (mem_data_valid) begin
          rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
          if (rcv_cnt_q == LAST_CNT) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_wr_ack = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    fill_we_i   = 1'b0;
    fill_we_d   = 1'b0;
    fill_done_i = 1'b0;
    fill_done_d = 1'b0;
    i_stall     = 1'b0;
    d_stall     = 1'b0;

    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (dmem_wr_req) begin
            dmem_wr_ack = 1'b1;
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = dmem_wr_addr;
            mem_wdata   = dmem_wr_data;
          end
        end
        S_FILL: begin
          if (req_cnt_q < BLK_CNT) begin
            mem_en   = 1'b1;
            mem_addr = {base_q, req_cnt_q[WORD_W-1:0], 1'b0};
          end
          if (mem_data_valid) begin
            fill_data   = mem_rdata;
            fill_word   = rcv_cnt_q[WORD_W-1:0];
            fill_we_i   = (owner_q == OWN_I);
            fill_we_d   = (owner_q == OWN_D);
            fill_done_i = (owner_q == OWN_I) && (rcv_cnt_q == LAST_CNT);
            fill_done_d = (owner_q == OWN_D) && (rcv_cnt_q == LAST_CNT);
          end
        end
        default: ;
      endcase

      i_stall = icache_miss | (state_q != S_IDLE && owner_q == OWN_I);
      d_stall = dcache_miss | (dmem_wr_req & ~dmem_wr_ack) | (state_q != S_IDLE && owner_q == OWN_D);
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter: expected reads, fills and stores are queued at stimulus time
// and matched by a negedge monitor against a 4-cycle pipelined memory model.
module tb_mem_fill_arbiter;

  localparam int MEM_LAT   = 4;
  localparam int BLK_WORDS = 8;
  localparam int FILL_CYC  = 1 + BLK_WORDS + MEM_LAT - 1;  // miss cycle to fill_done

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss, dmem_wr_req;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dmem_wr_addr, dmem_wr_data;
  logic        dmem_wr_ack, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic        mem_data_valid;
  logic [2:0]  fill_word;
  logic        fill_we_i, fill_we_d, fill_done_i, fill_done_d, i_stall, d_stall;

  int checks = 0;
  int errors = 0;

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dmem_wr_req(dmem_wr_req), .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data),
    .dmem_wr_ack(dmem_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
    .i_stall(i_stall), .d_stall(d_stall)
  );

  always #5 clk = ~clk;

  // Pipelined memory: a read issued in cycle c returns data in cycle c+MEM_LAT.
  logic [MEM_LAT-1:0] pipe_v = '0;
  logic [15:0]        pipe_d [MEM_LAT];
  logic [15:0]        data_bias = 16'h0000;
  logic               stray_v = 1'b0;
  logic [15:0]        stray_d = 16'h0000;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[MEM_LAT-2:0], (mem_en === 1'b1 && mem_wr === 1'b0)};
    pipe_d[0] <= data_bias + {13'd0, mem_addr[3:1]};
    for (int i = 1; i < MEM_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign mem_data_valid = pipe_v[MEM_LAT-1] | stray_v;
  assign mem_rdata      = stray_v ? stray_d : pipe_d[MEM_LAT-1];

  logic [59:0] all_outs;
  assign all_outs = {dmem_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                     fill_we_i, fill_we_d, fill_done_i, fill_done_d, i_stall, d_stall};

  typedef struct packed {
    logic        we_i;
    logic        we_d;
    logic [2:0]  word;
    logic [15:0] data;
    logic        done_i;
    logic        done_d;
  } fill_t;

  fill_t       fq[$];
  logic [15:0] rq[$];
  logic [31:0] sq[$];
  fill_t       got_f, exp_f;
  logic [15:0] exp_a;
  logic [31:0] exp_s;
  bit          exp_last_is_i = 1'b1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mem_en === 1'b1 && mem_wr === 1'b0) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL read_issue: unexpected read addr=%h", mem_addr);
      end else begin
        exp_a = rq.pop_front();
        if (mem_addr !== exp_a) begin
          errors++;
          $display("FAIL read_issue: addr=%h expected %h", mem_addr, exp_a);
        end
      end
    end
    if (mem_en === 1'b1 && mem_wr === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL store_issue: unexpected store addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        exp_s = sq.pop_front();
        if ({dmem_wr_ack, mem_addr, mem_wdata} !== {1'b1, exp_s}) begin
          errors++;
          $display("FAIL store_issue: ack=%b addr=%h data=%h expected ack=1 addr=%h data=%h",
                   dmem_wr_ack, mem_addr, mem_wdata, exp_s[31:16], exp_s[15:0]);
        end
      end
    end
    if (fill_we_i || fill_we_d || fill_done_i || fill_done_d) begin
      checks++;
      got_f = {fill_we_i, fill_we_d, fill_word, fill_data, fill_done_i, fill_done_d};
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fill_write: unexpected fill we_i=%b we_d=%b word=%0d data=%h",
                 fill_we_i, fill_we_d, fill_word, fill_data);
      end else begin
        exp_f = fq.pop_front();
        if (got_f !== exp_f) begin
          errors++;
          $display("FAIL fill_write: got we_i=%b we_d=%b word=%0d data=%h done=%b%b expected we_i=%b we_d=%b word=%0d data=%h done=%b%b",
                   got_f.we_i, got_f.we_d, got_f.word, got_f.data, got_f.done_i, got_f.done_d,
                   exp_f.we_i, exp_f.we_d, exp_f.word, exp_f.data, exp_f.done_i, exp_f.done_d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fill(input bit is_i, input logic [15:0] addr, input int n_words);
    fill_t f;
    for (int w = 0; w < BLK_WORDS; w++) rq.push_back({addr[15:4], w[2:0], 1'b0});
    for (int w = 0; w < n_words; w++) begin
      f.we_i   = is_i;
      f.we_d   = ~is_i;
      f.word   = w[2:0];
      f.data   = data_bias + 16'(w);
      f.done_i = is_i && (w == BLK_WORDS - 1);
      f.done_d = !is_i && (w == BLK_WORDS - 1);
      fq.push_back(f);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h expected all zero", name, all_outs);
    end
  endtask

  // Holds a miss until its fill_done is seen, then drops it; n = negedges observed.
  task automatic serve(input bit is_i, input int budget, output int n);
    bit done = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      checks++;
      if ((is_i ? i_stall : d_stall) !== 1'b1) begin
        errors++;
        $display("FAIL serve_stall: %s_stall=%b expected 1 while miss held", is_i ? "i" : "d",
                 is_i ? i_stall : d_stall);
      end
      checks++;
      if (dmem_wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL serve_ack: dmem_wr_ack=%b expected 0 while filling", dmem_wr_ack);
      end
      if (dmem_wr_req === 1'b1) begin
        checks++;
        if (d_stall !== 1'b1) begin
          errors++;
          $display("FAIL store_wait_stall: d_stall=%b expected 1", d_stall);
        end
      end
      if (fill_we_i && !dcache_miss && !dmem_wr_req) begin
        checks++;
        if (d_stall !== 1'b0) begin
          errors++;
          $display("FAIL i_fill_dstall: d_stall=%b expected 0", d_stall);
        end
      end
      if (fill_we_d && !icache_miss) begin
        checks++;
        if (i_stall !== 1'b0) begin
          errors++;
          $display("FAIL d_fill_istall: i_stall=%b expected 0", i_stall);
        end
      end
      done = is_i ? fill_done_i : fill_done_d;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout: no fill_done_%s within %0d cycles", is_i ? "i" : "d", budget);
    end
    step();
    if (is_i) icache_miss = 1'b0;
    else      dcache_miss = 1'b0;
  endtask

  task automatic wait_word(input bit is_i, input logic [2:0] word, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = (is_i ? fill_we_i : fill_we_d) && fill_word == word;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_word: word %0d never written", word);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    icache_miss = 1'b0; icache_miss_addr = '0;
    dcache_miss = 1'b0; dcache_miss_addr = '0;
    dmem_wr_req = 1'b0; dmem_wr_addr = '0; dmem_wr_data = '0;
    step();
    step();
    @(negedge clk);
    check_quiet("reset_active");
    step();
    rst = 1'b0;
    @(negedge clk);
    check_quiet("reset_idle");
  endtask

  task automatic test_icache_fill();
    int n;
    step();
    data_bias = 16'hA000;
    push_fill(1'b1, 16'h1236, BLK_WORDS);
    icache_miss_addr = 16'h1236;
    icache_miss = 1'b1;
    serve(1'b1, 40, n);
    exp_last_is_i = 1'b1;
    checks++;
    if (n - 1 !== FILL_CYC) begin
      errors++;
      $display("FAIL ifill_latency: done %0d cycles after miss expected %0d", n - 1, FILL_CYC);
    end
    @(negedge clk);
    checks++;
    if (i_stall !== 1'b1) begin
      errors++;
      $display("FAIL ifill_done_stall: i_stall=%b expected 1 in DONE", i_stall);
    end
    @(negedge clk);
    check_quiet("ifill_back_idle");
  endtask

  task automatic test_tie(input string name);
    int  n;
    bit  d_first;
`ifdef ARB_RR_EN
    d_first = exp_last_is_i;
`else
    d_first = 1'b1;
`endif
    step();
    data_bias = 16'h5000;
    if (d_first) begin
      push_fill(1'b0, 16'h8010, BLK_WORDS);
      push_fill(1'b1, 16'h0040, BLK_WORDS);
    end else begin
      push_fill(1'b1, 16'h0040, BLK_WORDS);
      push_fill(1'b0, 16'h8010, BLK_WORDS);
    end
    icache_miss_addr = 16'h0040;
    dcache_miss_addr = 16'h8010;
    icache_miss = 1'b1;
    dcache_miss = 1'b1;
    serve(~d_first, 40, n);
    checks++;
    if (n - 1 !== FILL_CYC) begin
      errors++;
      $display("FAIL %s_first_latency: %0d cycles expected %0d", name, n - 1, FILL_CYC);
    end
    serve(d_first, 40, n);
    exp_last_is_i = d_first;
    step();
    @(negedge clk);
    check_quiet({name, "_idle"});
  endtask

  task automatic test_lone_dmiss();
    int n;
    step();
    data_bias = 16'h9000;
    push_fill(1'b0, 16'h9008, BLK_WORDS);
    dcache_miss_addr = 16'h9008;
    dcache_miss = 1'b1;
    serve(1'b0, 40, n);
    exp_last_is_i = 1'b0;
    step();
  endtask

  task automatic test_store_idle();
    step();
    sq.push_back({16'h2002, 16'hBEEF});
    dmem_wr_addr = 16'h2002;
    dmem_wr_data = 16'hBEEF;
    dmem_wr_req  = 1'b1;
    @(negedge clk);
    checks++;
    if ({dmem_wr_ack, d_stall, i_stall} !== 3'b100) begin
      errors++;
      $display("FAIL store_idle: ack/d_stall/i_stall=%b expected 100", {dmem_wr_ack, d_stall, i_stall});
    end
    step();
    dmem_wr_req = 1'b0;
    @(negedge clk);
    check_quiet("store_idle_after");
  endtask

  task automatic test_store_during_fill();
    int n;
    step();
    data_bias = 16'h3000;
    push_fill(1'b1, 16'h6000, BLK_WORDS);
    icache_miss_addr = 16'h6000;
    icache_miss = 1'b1;
    wait_word(1'b1, 3'd3, 30);
    step();
    sq.push_back({16'h4444, 16'h1234});
    dmem_wr_addr = 16'h4444;
    dmem_wr_data = 16'h1234;
    dmem_wr_req  = 1'b1;
    serve(1'b1, 30, n);
    @(negedge clk);
    checks++;
    if ({dmem_wr_ack, d_stall} !== 2'b01) begin
      errors++;
      $display("FAIL store_done_wait: ack/d_stall=%b expected 01", {dmem_wr_ack, d_stall});
    end
    @(negedge clk);
    checks++;
    if ({dmem_wr_ack, d_stall, mem_wr} !== 3'b101) begin
      errors++;
      $display("FAIL store_after_fill: ack/d_stall/mem_wr=%b expected 101", {dmem_wr_ack, d_stall, mem_wr});
    end
    step();
    dmem_wr_req = 1'b0;
    @(negedge clk);
    check_quiet("store_after_fill_drop");
  endtask

  task automatic test_reset_mid_fill();
    int n;
    step();
    data_bias = 16'h7000;
    push_fill(1'b1, 16'h5550, 4);
    icache_miss_addr = 16'h5550;
    icache_miss = 1'b1;
    wait_word(1'b1, 3'd3, 30);
    step();
    rst = 1'b1;
    icache_miss = 1'b0;
    step();
    rst = 1'b0;
    exp_last_is_i = 1'b1;
    for (int c = 0; c < MEM_LAT; c++) begin
      @(negedge clk);
      check_quiet("reset_mid_fill");
      step();
    end
    data_bias = 16'h7100;
    push_fill(1'b1, 16'h5550, BLK_WORDS);
    icache_miss = 1'b1;
    serve(1'b1, 40, n);
    checks++;
    if (n - 1 !== FILL_CYC) begin
      errors++;
      $display("FAIL refill_latency: %0d cycles expected %0d", n - 1, FILL_CYC);
    end
    step();
  endtask

  task automatic test_stray_valid();
    step();
    stray_d = 16'hDEAD;
    stray_v = 1'b1;
    @(negedge clk);
    check_quiet("stray_valid");
    step();
    stray_v = 1'b0;
    @(negedge clk);
    check_quiet("stray_valid_after");
  endtask

  task automatic test_drain();
    step();
    step();
    checks++;
    if (rq.size() != 0 || fq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending reads=%0d fills=%0d stores=%0d expected 0", rq.size(), fq.size(), sq.size());
    end
  endtask

  initial begin
    test_reset();
    test_icache_fill();
    test_tie("tie1");
    test_lone_dmiss();
    test_tie("tie2");
    test_store_idle();
    test_store_during_fill();
    test_reset_mid_fill();
    test_stray_valid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
